// File: rtl/scramble_pkg.sv
// Shared types and constants for the scramble sequencer and its move decoder.
package scramble_pkg;

    localparam int MOVE_W        = 3;
    localparam int DEF_NUM_MOVES = 16;
    localparam int DEF_MOVE_GAP  = 4;

    typedef enum logic [1:0] {
        GAP   = 2'd0,
        ISSUE = 2'd1,
        PLAY  = 2'd2
    } state_t;

    // The switch checker flags anything other than exactly one set bit, so
    // a priority encode loses nothing on the non-error path.
    function automatic logic [1:0] onehot_to_idx(input logic [3:0] oh);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (oh[i]) idx = 2'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/move_decoder.sv
// Turns a row/column select plus a 2-bit line index into one-hot row/col enables.
module move_decoder (
    input  logic       sel_col,
    input  logic [1:0] idx,
    input  logic       error,
    output logic [3:0] row,
    output logic [3:0] col
);

    logic [3:0] line;

    always_comb begin
        line = 4'b0001 << idx;
        row  = '0;
        col  = '0;
        if (!error) begin
            if (sel_col) col = line;
            else         row = line;
        end
    end

endmodule

// File: rtl/scramble_sequencer.sv
// Move-source controller for the 4x4 cell array: random scramble, then player moves.
// Optional SCRAMBLE_NO_REPEAT_EN: redraw instead of issuing a move equal to the previous one.
//
// state | meaning
// GAP   | idle countdown before the next scramble move, row/col held at 0
// ISSUE | decode rand_bits into one move and strobe fire
// PLAY  | scramble finished, player switches and fire button drive the cells
module scramble_sequencer
    import scramble_pkg::*;
#(
    parameter int NUM_MOVES = DEF_NUM_MOVES,
    parameter int MOVE_GAP  = DEF_MOVE_GAP
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [MOVE_W-1:0] rand_bits,
    input  logic              user_fire,
    input  logic              user_nRow,
    input  logic [3:0]        user_row_column,
    input  logic              user_error,
    output logic [3:0]        row,
    output logic [3:0]        col,
    output logic              fire,
    output logic              scrambling,
    output logic              done
);

    localparam int MW = $clog2(NUM_MOVES + 1);
    localparam int GW = $clog2(MOVE_GAP + 1);
    localparam logic [MW-1:0] MOVES_LOAD = MW'(NUM_MOVES);
    localparam logic [GW-1:0] GAP_LOAD   = GW'(MOVE_GAP);

    state_t          state_q, state_d;
    logic [MW-1:0]   moves_q, moves_d;
    logic [GW-1:0]   gap_q, gap_d;
    logic            fire_hist_q;
    logic            repeat_move;

    logic [3:0]      rnd_row, rnd_col, usr_row, usr_col;
    logic [3:0]      row_d, col_d;
    logic            fire_d, done_d, scrambling_d;

    move_decoder u_rnd_dec (
        .sel_col (rand_bits[2]),
        .idx     (rand_bits[1:0]),
        .error   (1'b0),
        .row     (rnd_row),
        .col     (rnd_col)
    );

    move_decoder u_usr_dec (
        .sel_col (user_nRow),
        .idx     (onehot_to_idx(user_row_column)),
        .error   (user_error),
        .row     (usr_row),
        .col     (usr_col)
    );

`ifdef SCRAMBLE_NO_REPEAT_EN
    logic              prev_valid_q;
    logic [MOVE_W-1:0] prev_move_q;

    assign repeat_move = prev_valid_q && (prev_move_q == rand_bits);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_valid_q <= 1'b0;
            prev_move_q  <= '0;
        end else if (state_q == PLAY && start) begin
            prev_valid_q <= 1'b0;
            prev_move_q  <= '0;
        end else if (state_q == ISSUE && !repeat_move) begin
            prev_valid_q <= 1'b1;
            prev_move_q  <= rand_bits;
        end
    end
`else
    assign repeat_move = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        moves_d      = moves_q;
        gap_d        = gap_q;
        row_d        = '0;
        col_d        = '0;
        fire_d       = 1'b0;
        done_d       = 1'b0;
        scrambling_d = 1'b1;
        case (state_q)
            GAP: begin
                gap_d = gap_q - 1'b1;
                if (gap_q == GW'(1)) state_d = ISSUE;
            end
            ISSUE: begin
                if (!repeat_move) begin
                    row_d   = rnd_row;
                    col_d   = rnd_col;
                    fire_d  = 1'b1;
                    moves_d = moves_q - 1'b1;
                    if (moves_q == MW'(1)) begin
                        state_d = PLAY;
                    end else begin
                        gap_d   = GAP_LOAD;
                        state_d = GAP;
                    end
                end
            end
            PLAY: begin
                scrambling_d = 1'b0;
                // scrambling is still high only during the first PLAY cycle
                done_d       = scrambling && !start;
                if (start) begin
                    moves_d      = MOVES_LOAD;
                    gap_d        = GAP_LOAD;
                    scrambling_d = 1'b1;
                    state_d      = GAP;
                end else begin
                    row_d  = usr_row;
                    col_d  = usr_col;
                    fire_d = user_fire && !fire_hist_q && !user_error;
                end
            end
            default: state_d = GAP;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= GAP;
            moves_q     <= MOVES_LOAD;
            gap_q       <= GAP_LOAD;
            fire_hist_q <= 1'b0;
            row         <= '0;
            col         <= '0;
            fire        <= 1'b0;
            done        <= 1'b0;
            scrambling  <= 1'b1;
        end else begin
            state_q     <= state_d;
            moves_q     <= moves_d;
            gap_q       <= gap_d;
            fire_hist_q <= user_fire;
            row         <= row_d;
            col         <= col_d;
            fire        <= fire_d;
            done        <= done_d;
            scrambling  <= scrambling_d;
        end
    end

endmodule

// File: doc/scramble_sequencer.md
# scramble_sequencer

Move-source controller in front of the 4x4 cell array. After reset, or on a new-game request, it issues a fixed number of random row/column moves to scramble the board. It then hands the move path to the player. It replaces the hardwired scramble path in the top level and drives the `row`, `col` and `fire` enables seen by every cell.

## Interface
Parameters:
- `NUM_MOVES`, default 16: random moves issued per scramble; legal range ≥1.
- `MOVE_GAP`, default 4: idle cycles before each scramble move; legal range ≥1.

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  single-cycle new-game request.
- `rand_bits`  in  3  output of the LFSR. Bit 2 selects column (1) or row (0). Bits 1:0 give the line index.
- `user_fire`  in  1  debounced fire button level.
- `user_nRow`  in  1  0 = row selected, 1 = column selected.
- `user_row_column`  in  4  one-hot line select from switch checker.
- `user_error`  in  1  switch checker error (not exactly one switch set).
- `row`  out  4  one-hot row enable to cells.
- `col`  out  4  one-hot column enable to cells.
- `fire`  out  1  single-cycle move strobe to cells.
- `scrambling`  out  1  high while random moves are being issued.
- `done`  out  1  single-cycle pulse on entry to PLAY.

## Operation
- All outputs are registered.
- Reset values: `row`=0, `col`=0, `fire`=0, `done`=0, `scrambling`=1. Internal state: state=GAP, gap counter=MOVE_GAP, moves_left=NUM_MOVES, fire history=0.
- GAP:
  - Decrement the gap counter each cycle.
  - When the counter reaches 0, go to ISSUE.
  - `row`/`col` are 0.
- ISSUE (one cycle):
  - Decode `rand_bits` into exactly one set bit of `row` or `col`.
  - Drive `fire`=1.
  - Decrement moves_left.
  - If moves_left becomes 0, go to PLAY. Otherwise reload the gap counter and go to GAP.
- PLAY:
  - `scrambling`=0. `done` is high only on the first PLAY cycle.
  - If `user_error`=1: `row`=`col`=0.
  - Otherwise `user_row_column` goes to `row` when `user_nRow`=0 and to `col` when `user_nRow`=1.
  - `fire` pulses for one cycle on each rising edge of `user_fire`. It is suppressed while `user_error`=1.
- `start` in PLAY:
  - Reload moves_left and the gap counter.
  - Set `scrambling`=1 and go to GAP.
  - Clear `row`/`col` on the next cycle.
- `start` in GAP or ISSUE is ignored; no restart occurs.
- `user_fire` is ignored outside PLAY.
  - The edge history register still samples `user_fire` every cycle.
  - Consequence: a button held across the PLAY transition produces no fire pulse.
- Counter widths:
  - moves_left: $clog2(NUM_MOVES+1).
  - gap counter: $clog2(MOVE_GAP+1).
  - Neither counter wraps; both reload only on the events above.

## Timing
- Scramble period is MOVE_GAP+1 cycles per move. First move: `fire` is high on cycle MOVE_GAP+1 after reset deasserts.
- `row`/`col` are valid in the same cycle `fire` is high, and return to 0 the cycle after in GAP.
- `done` and `scrambling`=0 both appear in the cycle after the last ISSUE.
- User `fire` latency is 1 cycle from the `user_fire` rising edge seen at the input; `row`/`col` follow the switches with 1-cycle latency.
- Reset asserted mid-scramble or in PLAY: all state returns to the reset values immediately (asynchronously), and the scramble restarts from the full NUM_MOVES count.

## Configuration
- `SCRAMBLE_NO_REPEAT_EN`
  - Defined: in ISSUE, if the decoded move (row/column select and index) equals the previously issued scramble move:
    - no `fire`;
    - moves_left is not decremented;
    - the block stays in ISSUE and redraws on the next cycle.
  - The previous-move register is cleared by `reset` and `start`.
  - Undefined: every draw is issued; repeats are allowed.

## Structure
- Package `scramble_pkg`:
  - state encoding localparams: GAP, ISSUE, PLAY;
  - move width constant (3);
  - default NUM_MOVES / MOVE_GAP.
- Sub-module `move_decoder`: combinational, takes a select bit, index and error, and produces one-hot `row`/`col`. It is instantiated twice, once for the random path and once for the user path.

## Test plan
- NUM_MOVES=4, MOVE_GAP=2, `rand_bits`=3'b101 held, reset released:
  - `fire` is high on cycles 3, 6, 9, 12 with `col`=4'b0010, `row`=0;
  - `done` pulses on cycle 13, and `scrambling` falls on cycle 13.
- In PLAY with `user_nRow`=0, `user_row_column`=4'b0100, `user_fire` rising edge: exactly one `fire` cycle with `row`=4'b0100, `col`=0. Holding `user_fire` for 50 cycles gives no further pulses.
- In PLAY with `user_error`=1 and a `user_fire` edge: `fire`=0 and `row`=`col`=0.
- `start` pulsed during move 2 of a scramble is ignored; exactly NUM_MOVES fires occur. `start` in PLAY produces a new scramble of NUM_MOVES fires.
- `reset` asserted during GAP after 2 moves: outputs return to reset values in the same cycle. After release, the full 4 moves are reissued.
- With `SCRAMBLE_NO_REPEAT_EN` and `rand_bits` held at 3'b011: only 1 `fire` is issued and the block stays in ISSUE with no `done`. Changing `rand_bits` to alternate 3'b011/3'b000 completes 4 moves.
